// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Sequential packed-BCD to binary converter. Uses reverse
//            shift-and-subtract-3 with one iteration per clock and a
//            start/done handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIGITS : number of BCD digits in the operand (digit 0 in bits [3:0])
//   BIN_W  : result width, 2^BIN_W must exceed 10^DIGITS - 1
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   start  : conversion request, only honoured in IDLE
//   bcd    : packed BCD operand, captured on the edge that accepts start
//   busy   : high while iterating (SHIFT state)
//   done   : one-cycle pulse, bin and err valid
//   err    : operand held a nibble > 9; held until the next accepted start
//   bin    : binary result; held until the next accepted start
// ============================================================================
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin
);

    localparam int c_BCD_W  = 4 * DIGITS;
    localparam int c_WORK_W = c_BCD_W + BIN_W;
    localparam int c_CNT_W  = $clog2(BIN_W + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIN_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [c_WORK_W-1:0] r_work;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [BIN_W-1:0]    r_bin;
    logic                r_err;
    logic                r_busy;
    logic                r_done;

    logic [c_WORK_W-1:0] w_shifted;
    logic [c_WORK_W-1:0] w_work_next;
    logic [DIGITS-1:0]   w_nib_bad;
    logic                w_bad;

    // Upper field holds the BCD digits, lower field collects binary bits
    // as they fall out of digit 0.
    assign w_shifted = r_work >> 1;
    assign w_work_next[BIN_W-1:0] = w_shifted[BIN_W-1:0];

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] w_nib;
            // A digit that received the LSB of its upper neighbour now
            // carries +8 where it should carry +5: take 3 back off.
            assign w_nib = w_shifted[BIN_W + 4*i +: 4];
            assign w_work_next[BIN_W + 4*i +: 4] =
                (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
            assign w_nib_bad[i] = (bcd[4*i +: 4] > 4'd9);
        end
    endgenerate

    assign w_bad = |w_nib_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_work <= {bcd, {BIN_W{1'b0}}};
                        r_cnt  <= '0;
                        if (w_bad) begin
                            // Malformed operand: report at once, no shifting.
                            r_state <= c_DONE;
                            r_err   <= 1'b1;
                            r_bin   <= '0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= c_SHIFT;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                c_SHIFT: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_bin   <= w_work_next[BIN_W-1:0];
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign bin  = r_bin;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Purpose  : Self-checking bench for bcd_to_bin (DIGITS=3, BIN_W=10).
//            Directed vector table, full 000-999 sweep, and hand-written
//            sequences for ignored start and mid-conversion reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  bin;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    bcd_to_bin #(
        .DIGITS(3),
        .BIN_W (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .bcd  (bcd),
        .busy (busy),
        .done (done),
        .err  (err),
        .bin  (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle. Issues one start, then
    // samples 12 cycles (j=0 after the accepting edge .. j=11), which leaves
    // the caller positioned for a back-to-back start. Optionally pokes a
    // second start at sample index poke_j.
    task automatic run_conv(input logic [11:0] b, input int poke_j,
                            input logic [11:0] poke_b,
                            output logic [9:0] o_bin, output logic o_err,
                            output int n_busy, output int n_done,
                            output int done_j, output logic [9:0] bin_after,
                            output logic err_after);
        o_bin = '0; o_err = 1'b0; n_busy = 0; n_done = 0; done_j = -1;
        start = 1'b1;
        bcd   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                done_j = j;
                o_bin  = bin;
                o_err  = err;
            end
            bin_after = bin;
            err_after = err;
            if (j == poke_j) begin
                start = 1'b1;
                bcd   = poke_b;
            end else begin
                start = 1'b0;
            end
            if (j < 11) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    task automatic conv_check(input string tag, input logic [11:0] b,
                              input logic [9:0] exp_bin, input logic exp_err,
                              input int poke_j, input logic [11:0] poke_b);
        logic [9:0] g_bin, a_bin;
        logic       g_err, a_err;
        int         nb, nd, dj;
        run_conv(b, poke_j, poke_b, g_bin, g_err, nb, nd, dj, a_bin, a_err);
        check({tag, " done_count"}, nd, 1);
        check({tag, " done_latency"}, dj, exp_err ? 0 : 10);
        check({tag, " busy_cycles"}, nb, exp_err ? 0 : 10);
        check({tag, " bin"}, int'(g_bin), int'(exp_bin));
        check({tag, " err"}, int'(g_err), int'(exp_err));
        check({tag, " bin_hold"}, int'(a_bin), int'(exp_bin));
        check({tag, " err_hold"}, int'(a_err), int'(exp_err));
    endtask

    initial begin
        int bad;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        bcd     = '0;

        vecs[0]  = '{12'h999, 10'd999, 1'b0};
        vecs[1]  = '{12'h000, 10'd0,   1'b0};
        vecs[2]  = '{12'h001, 10'd1,   1'b0};
        vecs[3]  = '{12'h009, 10'd9,   1'b0};
        vecs[4]  = '{12'h010, 10'd10,  1'b0};
        vecs[5]  = '{12'h099, 10'd99,  1'b0};
        vecs[6]  = '{12'h100, 10'd100, 1'b0};
        vecs[7]  = '{12'h512, 10'd512, 1'b0};
        vecs[8]  = '{12'h0F0, 10'd0,   1'b1};
        vecs[9]  = '{12'h90A, 10'd0,   1'b1};
        vecs[10] = '{12'h1A5, 10'd0,   1'b1};
        vecs[11] = '{12'h042, 10'd42,  1'b0};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset bin",  int'(bin),  0);
        check("reset err",  int'(err),  0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);

        // Idle with start low: nothing may move.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (busy || done || err || bin != 10'd0) bad++;
        end
        check("idle_20 disturbed_cycles", bad, 0);

        for (int i = 0; i < 12; i++)
            conv_check($sformatf("vec%0d(%h)", i, vecs[i].bcd), vecs[i].bcd,
                       vecs[i].bin, vecs[i].err, -1, 12'h000);

        // Every valid operand, back to back.
        for (int d = 0; d < 1000; d++) begin
            logic [11:0] b;
            b = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
            conv_check($sformatf("sweep%0d", d), b, 10'(d), 1'b0, -1, 12'h000);
        end

        // A second start during SHIFT is dropped.
        conv_check("ignore_start(500)", 12'h500, 10'd500, 1'b0, 3, 12'h123);

        // Reset in the middle of a conversion.
        conv_check("pre_reset(042)", 12'h042, 10'd42, 1'b0, -1, 12'h000);
        start = 1'b1;
        bcd   = 12'h777;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_shift busy", int'(busy), 1);
        check("mid_shift bin_prev", int'(bin), 42);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("after_reset busy", int'(busy), 0);
        check("after_reset done", int'(done), 0);
        check("after_reset bin",  int'(bin),  0);
        check("after_reset err",  int'(err),  0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (busy || done || bin != 10'd0) bad++;
        end
        check("after_reset quiet_cycles", bad, 0);
        conv_check("post_reset(777)", 12'h777, 10'd777, 1'b0, -1, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
